// File: rtl/sha3_absorb_ctrl.sv
// Keccak absorb sequencer: moves FIFO bytes into the sponge rate lanes, appends
// SHA3/SHAKE padding and hands each full rate block to the f-permutation.
module sha3_absorb_ctrl #(
  parameter int unsigned LEN_W     = 16,
  parameter logic [7:0]  DOM_SHA3  = 8'h06,
  parameter logic [7:0]  DOM_SHAKE = 8'h1F
) (
  input  logic             rclk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic             xof,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             abs_valid,
  output logic [7:0]       abs_data,
  output logic [7:0]       abs_idx,
  output logic             perm_start,
  input  logic             perm_done,
  output logic [2:0]       full_state,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BLOCK    = 3'd1,
    ST_MANY_PAD = 3'd2,
    ST_C_PAD    = 3'd3,
    ST_F_FUN    = 3'd4,
    ST_F_OUT    = 3'd5
  } state_e;

  localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] REM_ZERO = LEN_W'(0);

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [7:0]       idx_q;
  logic [1:0]       sel_q;
  logic             xof_q;
  logic             pad_pending_q;
  logic             pad_first_q;
  logic             perm_issued_q;
  logic             in_ready_q;
  logic             abs_valid_q;
  logic [7:0]       abs_data_q;
  logic [7:0]       abs_idx_q;
  logic             perm_start_q;
  logic             busy_q;
  logic             done_q;

  logic [7:0]       rate_last_s;
  logic [7:0]       pad_byte_s;

  // Highest byte index of the rate selected by the latched sel.
  function automatic logic [7:0] rate_last_f(input logic [1:0] s);
    logic [7:0] r;
    case (s)
      2'd0:    r = 8'd143;
      2'd1:    r = 8'd135;
      2'd2:    r = 8'd103;
      2'd3:    r = 8'd71;
      default: r = 8'd135;
    endcase
    return r;
  endfunction

  // Pad byte for the current position: domain byte first, 0x80 on the final lane byte.
  always_comb begin
    rate_last_s = rate_last_f(sel_q);
    pad_byte_s  = 8'h00;
    if (pad_first_q) begin
      pad_byte_s = xof_q ? DOM_SHAKE : DOM_SHA3;
    end else begin
      pad_byte_s = 8'h00;
    end
    if (idx_q == rate_last_s) begin
      pad_byte_s = pad_byte_s | 8'h80;
    end else begin
      pad_byte_s = pad_byte_s;
    end
  end

  // Absorb FSM with all outputs registered.
  always_ff @(posedge rclk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rem_q         <= REM_ZERO;
      idx_q         <= 8'd0;
      sel_q         <= 2'd0;
      xof_q         <= 1'b0;
      pad_pending_q <= 1'b0;
      pad_first_q   <= 1'b0;
      perm_issued_q <= 1'b0;
      in_ready_q    <= 1'b0;
      abs_valid_q   <= 1'b0;
      abs_data_q    <= 8'h00;
      abs_idx_q     <= 8'd0;
      perm_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      abs_valid_q  <= 1'b0;
      perm_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_q         <= sel;
            xof_q         <= xof;
            rem_q         <= msg_len;
            idx_q         <= 8'd0;
            pad_pending_q <= 1'b0;
            perm_issued_q <= 1'b0;
            busy_q        <= 1'b1;
            if (msg_len != REM_ZERO) begin
              state_q    <= ST_BLOCK;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= ST_C_PAD;
              pad_first_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end
          end
        end
        ST_BLOCK: begin
          if (in_valid && in_ready_q) begin
            abs_valid_q <= 1'b1;
            abs_data_q  <= in_data;
            abs_idx_q   <= idx_q;
            rem_q       <= rem_q - REM_ONE;
            if (idx_q == rate_last_s) begin
              state_q       <= ST_F_FUN;
              pad_pending_q <= (rem_q == REM_ONE);
              perm_issued_q <= 1'b0;
              in_ready_q    <= 1'b0;
            end else if (rem_q == REM_ONE) begin
              state_q     <= ST_C_PAD;
              idx_q       <= idx_q + 8'd1;
              pad_first_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
        end
        ST_C_PAD, ST_MANY_PAD: begin
          abs_valid_q <= 1'b1;
          abs_data_q  <= pad_byte_s;
          abs_idx_q   <= idx_q;
          pad_first_q <= 1'b0;
          if (idx_q == rate_last_s) begin
            state_q       <= ST_F_FUN;
            pad_pending_q <= 1'b0;
            perm_issued_q <= 1'b0;
          end else begin
            idx_q <= idx_q + 8'd1;
          end
        end
        ST_F_FUN: begin
          // The first f_fun cycle carries the block's trailing abs write; launch one cycle later.
          if (!perm_issued_q) begin
            perm_start_q  <= 1'b1;
            perm_issued_q <= 1'b1;
            idx_q         <= 8'd0;
          end else if (perm_done) begin
            perm_issued_q <= 1'b0;
            if (rem_q != REM_ZERO) begin
              state_q    <= ST_BLOCK;
              in_ready_q <= 1'b1;
            end else if (pad_pending_q) begin
              state_q       <= ST_MANY_PAD;
              pad_first_q   <= 1'b1;
              pad_pending_q <= 1'b0;
            end else begin
              state_q <= ST_F_OUT;
              done_q  <= 1'b1;
            end
          end
        end
        ST_F_OUT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign abs_valid  = abs_valid_q;
  assign abs_data   = abs_data_q;
  assign abs_idx    = abs_idx_q;
  assign perm_start = perm_start_q;
  assign full_state = state_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Bench for sha3_absorb_ctrl: a padded-message model produces the expected stream of
// absorb writes, permutation launches and the done pulse, checked every cycle.
module tb_sha3_absorb_ctrl;

  logic        rclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        xof = 1'b0;
  logic [15:0] msg_len = 16'd0;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        abs_valid;
  logic [7:0]  abs_data;
  logic [7:0]  abs_idx;
  logic        perm_start;
  logic        perm_done;
  logic [2:0]  full_state;
  logic        busy;
  logic        done;

  sha3_absorb_ctrl #(.LEN_W(16)) dut (
    .rclk(rclk), .reset_n(reset_n), .start(start), .sel(sel), .xof(xof),
    .msg_len(msg_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abs_valid(abs_valid), .abs_data(abs_data), .abs_idx(abs_idx),
    .perm_start(perm_start), .perm_done(perm_done), .full_state(full_state),
    .busy(busy), .done(done)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [1:0] kind;   // 0 abs write, 1 perm_start, 2 done
    logic [7:0] idx;
    logic [7:0] data;
  } ev_t;

  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];
  logic [7:0]  msg [0:1023];
  int          run_len = 0;
  int          run_id = 0;
  bit          toggle_mode = 1'b0;
  int          perm_delay = 2;
  int          stray_req = 0;
  int          perm_cnt = 0;
  int          done_cnt = 0;
  int          p0;
  int          d0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rate_of(input logic [1:0] s);
    int tbl [4] = '{144, 136, 104, 72};
    return tbl[s];
  endfunction

  // Whole padded message: data, then DOM at position len, 0x80 ORed into the last byte.
  task automatic build(input logic [1:0] s, input logic x, input int len, input int mul, input int seed);
    int r;
    int padded;
    logic [7:0] b;
    r = rate_of(s);
    padded = ((len + r) / r) * r;
    exp_q.delete();
    for (int j = 0; j < len; j++) msg[j] = 8'((j * mul + seed) & 255);
    for (int j = 0; j < padded; j++) begin
      if (j < len) b = msg[j];
      else if (j == len) b = x ? 8'h1F : 8'h06;
      else b = 8'h00;
      if (j == padded - 1) b = b | 8'h80;
      exp_q.push_back({2'd0, 8'(j % r), b});
      if (j % r == r - 1) exp_q.push_back({2'd1, 8'd0, 8'd0});
    end
    exp_q.push_back({2'd2, 8'd0, 8'd0});
  endtask

  // FIFO-side and permutation-side responder.
  always @(negedge rclk) begin : drv
    static int ptr = 0;
    static int seen_run = 0;
    static bit hs = 1'b0;
    static bit pd_pending = 1'b0;
    static int pd_wait = 0;
    static int stray_ack = 0;
    if (run_id != seen_run) begin
      seen_run = run_id;
      ptr = 0;
      hs = 1'b0;
    end
    if (hs) ptr++;
    perm_done = 1'b0;
    if (!reset_n) begin
      in_valid = 1'b0;
      in_data = 8'h00;
      hs = 1'b0;
      pd_pending = 1'b0;
    end else begin
      in_valid = (ptr < run_len) && (!toggle_mode || ($urandom_range(1, 0) == 1));
      in_data = in_valid ? msg[ptr] : 8'h00;
      hs = in_valid && in_ready;
      if (perm_start) begin
        pd_pending = 1'b1;
        pd_wait = perm_delay;
      end
      if (pd_pending) begin
        if (pd_wait == 0) begin
          perm_done = 1'b1;
          pd_pending = 1'b0;
        end else begin
          pd_wait--;
        end
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        perm_done = 1'b1;
      end
    end
  end

  // Compare process: every DUT event must match the head of the expected stream.
  always @(negedge rclk) begin : cmp
    static logic [2:0] prev_state = 3'd0;
    ev_t e;
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      chk("busy_vs_state", busy, (full_state != 3'd0));
      if (full_state == 3'd0 || full_state == 3'd5 || (full_state == 3'd4 && prev_state == 3'd4))
        chk("abs_quiet", abs_valid, 1'b0);
      if (abs_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("abs_kind", e.kind, 2'd0);
        chk("abs_idx", abs_idx, e.idx);
        chk("abs_data", abs_data, e.data);
      end
      if (perm_start) begin
        perm_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("perm_kind", e.kind, 2'd1);
      end
      if (done) begin
        done_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("done_kind", e.kind, 2'd2);
      end
    end
    prev_state = full_state;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_abs_valid", abs_valid, 1'b0);
    chk("rst_perm_start", perm_start, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_abs_data", abs_data, 8'h00);
    chk("rst_abs_idx", abs_idx, 8'd0);
    chk("rst_state", full_state, 3'd0);
  endtask

  task automatic launch(input logic [1:0] s, input logic x, input int len, input int mul,
                        input int seed, input bit tog, input int dly);
    build(s, x, len, mul, seed);
    p0 = perm_cnt;
    d0 = done_cnt;
    toggle_mode = tog;
    perm_delay = dly;
    run_len = len;
    run_id++;
    sel = s;
    xof = x;
    msg_len = 16'(len);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic finish_run(input string name, input int exp_perms);
    for (int k = 0; k < 6000 && done_cnt == d0; k++) cyc(1);
    chk({name, "_done_count"}, done_cnt - d0, 1);
    cyc(2);
    chk({name, "_perm_count"}, perm_cnt - p0, exp_perms);
    chk({name, "_stream_drained"}, exp_q.size(), 0);
    chk({name, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    cyc(3);
    chk_reset_outputs();
    reset_n = 1'b1;
    cyc(2);

    // T1: empty SHA3-256 message -> single pad block
    launch(2'd1, 1'b0, 0, 1, 0, 1'b0, 2);
    chk("t1_model_first", exp_q[0].data, 8'h06);
    chk("t1_model_last", exp_q[135].data, 8'h80);
    chk("t1_model_len", exp_q.size(), 138);
    finish_run("t1", 1);

    // T2: pad collapses into one 0x86 byte
    launch(2'd1, 1'b0, 135, 1, 0, 1'b0, 2);
    chk("t2_model_pad", exp_q[135].data, 8'h86);
    chk("t2_model_b134", exp_q[134].data, 8'd134);
    finish_run("t2", 1);

    // T3: exact block -> extra padding-only block
    launch(2'd1, 1'b0, 136, 3, 5, 1'b0, 2);
    chk("t3_model_manypad", exp_q[137].data, 8'h06);
    finish_run("t3", 2);

    // T4: SHAKE, rate 72, bursty FIFO
    launch(2'd3, 1'b1, 100, 7, 1, 1'b1, 2);
    chk("t4_model_dom", exp_q[101].data, 8'h1F);
    chk("t4_model_dom_idx", exp_q[101].idx, 8'd28);
    chk("t4_model_end", exp_q[144].data, 8'h80);
    finish_run("t4", 2);

    // T5: rate 144, slow permutation; stray start and perm_done while busy
    launch(2'd0, 1'b0, 300, 11, 2, 1'b0, 20);
    cyc(10);
    sel = 2'd3;
    xof = 1'b1;
    msg_len = 16'd1;
    start = 1'b1;
    stray_req++;
    cyc(1);
    start = 1'b0;
    finish_run("t5", 3);

    // T6: abort mid-block with a start racing the reset, then a clean run
    launch(2'd2, 1'b0, 50, 1, 9, 1'b0, 2);
    cyc(20);
    reset_n = 1'b0;
    start = 1'b1;
    cyc(3);
    chk_reset_outputs();
    p0 = perm_cnt;
    start = 1'b0;
    reset_n = 1'b1;
    cyc(5);
    chk("t6_no_perm_after_abort", perm_cnt - p0, 0);
    chk("t6_idle_after_abort", full_state, 3'd0);
    launch(2'd1, 1'b0, 5, 1, 9, 1'b0, 2);
    finish_run("t6", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
